// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial 74181 controller: FSM state
// encoding, the 74181 function-select codes used by the microcode, and the
// legal range of the nibble count.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 74181 select codes; S_SUB and S_XOR share a code, the mode bit tells them apart
  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;
  localparam logic [3:0] S_OR  = 4'b1110;

  localparam int NIBBLES_MIN = 2;
  localparam int NIBBLES_MAX = 8;

  function automatic bit nibbles_legal(input int n);
    return (n >= NIBBLES_MIN) && (n <= NIBBLES_MAX);
  endfunction

endpackage

// File: rtl/alu_nibble_seq.sv
// Nibble-serial controller for one external 74181 slice. Latches wide
// operands on start, feeds one nibble per cycle to the slice, ripples the
// slice carry into the next nibble and assembles the wide result.
// Optional feature: define ALU_SEQ_ZERO_EN to add a registered 'zero' flag.
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   start,
  input  logic [3:0]             op_s,
  input  logic                   op_m,
  input  logic                   cin_,
  input  logic [4*NIBBLES-1:0]   opa,
  input  logic [4*NIBBLES-1:0]   opb,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout_,
  output logic                   aeqb_all,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_cn_,
  input  logic [3:0]             alu_f,
  input  logic                   alu_cn4_,
  input  logic                   alu_aeqb
`ifdef ALU_SEQ_ZERO_EN
  ,
  output logic                   zero
`endif
);

  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  generate
    if (!nibbles_legal(NIBBLES)) begin : g_bad_nibbles
      $error("alu_nibble_seq: NIBBLES must be in 2..8");
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_next;
  logic [NIBBLES-1:0][3:0] r_opa;
  logic [NIBBLES-1:0][3:0] r_opb;
  logic [NIBBLES-1:0][3:0] r_result;
  logic [NIBBLES-1:0][3:0] w_result_next;
  logic [3:0]              r_s;
  logic                    r_m;
  logic                    r_carry;
  logic                    r_aeq;
  logic                    r_cout;
  logic                    r_aeqb_all;
  logic [CW-1:0]           r_cnt;
  logic                    w_load;
  logic                    w_capture;
  logic                    w_last;

  assign w_last = (r_cnt == LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state plus load/capture strobes; start is only honoured outside RUN
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_capture = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result with the current slice output merged into the active nibble
  always_comb begin
    w_result_next        = r_result;
    w_result_next[r_cnt] = alu_f;
  end

  // Operand latch, carry ripple, A=B accumulation and final flags
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_opa      <= '0;
      r_opb      <= '0;
      r_result   <= '0;
      r_s        <= 4'h0;
      r_m        <= 1'b1;
      r_carry    <= 1'b1;
      r_aeq      <= 1'b0;
      r_cout     <= 1'b1;
      r_aeqb_all <= 1'b0;
      r_cnt      <= '0;
    end else if (w_load) begin
      r_opa   <= opa;
      r_opb   <= opb;
      r_s     <= op_s;
      r_m     <= op_m;
      r_carry <= cin_;
      r_aeq   <= 1'b1;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_result <= w_result_next;
      r_carry  <= alu_cn4_;
      r_aeq    <= r_aeq & alu_aeqb;
      if (w_last) begin
        r_cout     <= r_m ? 1'b1 : alu_cn4_;
        r_aeqb_all <= r_aeq & alu_aeqb;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_ZERO_EN
  logic r_zero;

  // Zero flag is updated together with the final nibble capture
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                r_zero <= 1'b0;
    else if (w_capture && w_last) r_zero <= (w_result_next == '0);
  end

  assign zero = r_zero;
`endif

  assign busy     = (r_state == ST_RUN);
  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign cout_    = r_cout;
  assign aeqb_all = r_aeqb_all;
  assign alu_a    = r_opa[r_cnt];
  assign alu_b    = r_opb[r_cnt];
  assign alu_s    = r_s;
  assign alu_m    = r_m;
  assign alu_cn_  = (r_state == ST_RUN) ? r_carry : 1'b1;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq: pairs the controller with a
// behavioural 74181 slice and checks results against a wide-arithmetic model.
module tb_alu_nibble_seq;
  import alu_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic           clk = 1'b0;
  logic           rst_ = 1'b0;
  logic           start = 1'b0;
  logic [3:0]     op_s = 4'h0;
  logic           op_m = 1'b0;
  logic           cin_ = 1'b1;
  logic [W-1:0]   opa = '0;
  logic [W-1:0]   opb = '0;
  logic           busy, done, cout_, aeqb_all, alu_m, alu_cn_;
  logic [W-1:0]   result;
  logic [3:0]     alu_a, alu_b, alu_s, alu_f;
  logic           alu_cn4_, alu_aeqb;
`ifdef ALU_SEQ_ZERO_EN
  logic           zero;
`endif

  int nChecks = 0;
  int nPass   = 0;
  int busyCycles;
  bit gotDone;
  logic cnTrace [NIB];
  logic [3:0] sTrace;
  logic mTrace;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_(rst_), .start(start), .op_s(op_s), .op_m(op_m),
    .cin_(cin_), .opa(opa), .opb(opb), .busy(busy), .done(done),
    .result(result), .cout_(cout_), .aeqb_all(aeqb_all),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m),
    .alu_cn_(alu_cn_), .alu_f(alu_f), .alu_cn4_(alu_cn4_), .alu_aeqb(alu_aeqb)
`ifdef ALU_SEQ_ZERO_EN
    , .zero(zero)
`endif
  );

  // Behavioural 74181 slice (active-high data, active-low carries)
  logic [3:0] devT1, devT2;
  logic [4:0] devSum;
  always_comb begin
    devT1    = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
    devT2    = (alu_a & ~alu_b & {4{alu_s[2]}}) | (alu_a & alu_b & {4{alu_s[3]}});
    devSum   = {1'b0, devT1} + {1'b0, devT2} + {4'b0000, ~alu_cn_};
    alu_f    = alu_m ? ~(devT1 ^ devT2) : devSum[3:0];
    alu_cn4_ = ~devSum[4];
    alu_aeqb = (alu_f == 4'hF);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed === expected) nPass++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Wide-word reference: plain arithmetic/logic on the full operands
  function automatic void refModel(input logic [3:0] s, input logic m, input logic cn,
                                   input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic co, output logic ae);
    logic [W:0] sum;
    logic [W-1:0] bb;
    r  = '0;
    co = 1'b1;
    if (!m) begin
      bb  = (s == S_SUB) ? ~b : b;
      sum = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ~cn};
      r   = sum[W-1:0];
      co  = ~sum[W];
    end else begin
      case (s)
        S_XOR:   r = a ^ b;
        S_AND:   r = a & b;
        S_OR:    r = a | b;
        default: r = '0;
      endcase
    end
    ae = (r == {W{1'b1}});
  endfunction

  // Present an operation and pulse start for one sampled edge, then scramble inputs
  task automatic applyStimulus(input logic [3:0] s, input logic m, input logic cn,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_s = s; op_m = m; cin_ = cn; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = W'($urandom); opb = W'($urandom); op_s = ~s; op_m = ~m; cin_ = ~cn;
  endtask

  // Wait (bounded) for done, recording busy length and per-nibble carry-in
  task automatic waitDone();
    busyCycles = 0;
    gotDone = 1'b0;
    for (int k = 0; k < 4 * NIB + 8 && !gotDone; k++) begin
      if (done) gotDone = 1'b1;
      else begin
        if (busy) begin
          if (busyCycles == 0) begin sTrace = alu_s; mTrace = alu_m; end
          if (busyCycles < NIB) cnTrace[busyCycles] = alu_cn_;
          busyCycles++;
        end
        @(posedge clk); #1;
      end
    end
    checkOutput("done_seen", {31'd0, gotDone}, 32'd1);
  endtask

  task automatic checkResult(input logic [3:0] s, input logic m, input logic cn,
                             input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r, bb;
    logic co, ae;
    logic [W:0] low;
    refModel(s, m, cn, a, b, r, co, ae);
    checkOutput("result", 32'(result), 32'(r));
    checkOutput("cout_", {31'd0, cout_}, {31'd0, co});
    checkOutput("aeqb_all", {31'd0, aeqb_all}, {31'd0, ae});
    checkOutput("busy_cycles", 32'(busyCycles), 32'(NIB));
    checkOutput("alu_s_latched", {28'd0, sTrace}, {28'd0, s});
    checkOutput("alu_m_latched", {31'd0, mTrace}, {31'd0, m});
`ifdef ALU_SEQ_ZERO_EN
    checkOutput("zero", {31'd0, zero}, {31'd0, (r == '0)});
`endif
    if (!m) begin
      bb = (s == S_SUB) ? ~b : b;
      for (int i = 0; i < NIB; i++) begin
        low = {1'b0, a & ((W'(1) << (4 * i)) - 1'b1)} + {1'b0, bb & ((W'(1) << (4 * i)) - 1'b1)}
              + {{W{1'b0}}, ~cn};
        checkOutput($sformatf("alu_cn_nib%0d", i), {31'd0, cnTrace[i]}, {31'd0, ~low[4 * i]});
      end
    end
  endtask

  task automatic runOp(input logic [3:0] s, input logic m, input logic cn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic co, ae;
    applyStimulus(s, m, cn, a, b);
    waitDone();
    checkResult(s, m, cn, a, b);
    refModel(s, m, cn, a, b, r, co, ae);
    @(posedge clk); #1;
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    checkOutput("result_held", 32'(result), 32'(r));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_result"}, 32'(result), 32'd0);
    checkOutput({tag, "_cout_"}, {31'd0, cout_}, 32'd1);
    checkOutput({tag, "_aeqb_all"}, {31'd0, aeqb_all}, 32'd0);
    checkOutput({tag, "_alu_a"}, {28'd0, alu_a}, 32'd0);
    checkOutput({tag, "_alu_b"}, {28'd0, alu_b}, 32'd0);
    checkOutput({tag, "_alu_s"}, {28'd0, alu_s}, 32'd0);
    checkOutput({tag, "_alu_m"}, {31'd0, alu_m}, 32'd1);
    checkOutput({tag, "_alu_cn_"}, {31'd0, alu_cn_}, 32'd1);
`ifdef ALU_SEQ_ZERO_EN
    checkOutput({tag, "_zero"}, {31'd0, zero}, 32'd0);
`endif
  endtask

  logic [3:0] opS [5];
  logic       opM [5];

  initial begin
    logic [W-1:0] r, r1;
    logic co, ae;
    int donePulses;
    logic [W-1:0] resAtDone;
    int pick;

    opS[0] = S_ADD; opM[0] = 1'b0;
    opS[1] = S_SUB; opM[1] = 1'b0;
    opS[2] = S_XOR; opM[2] = 1'b1;
    opS[3] = S_AND; opM[3] = 1'b1;
    opS[4] = S_OR;  opM[4] = 1'b1;

    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst_ = 1'b1;

    $display("[TB] directed operations");
    runOp(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF);
    runOp(S_ADD, 1'b0, 1'b1, 16'hFFFF, 16'h0001);
    runOp(S_SUB, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A);
    runOp(S_SUB, 1'b0, 1'b1, 16'h5A5A, 16'h5A5B);
    runOp(S_XOR, 1'b1, 1'b1, 16'hF0F0, 16'hFF00);
    runOp(S_XOR, 1'b1, 1'b0, 16'h3C3C, 16'h3C3C);
    runOp(S_ADD, 1'b0, 1'b0, 16'h7FFF, 16'h0000);

    $display("[TB] start during RUN is ignored");
    applyStimulus(S_ADD, 1'b0, 1'b1, 16'h1111, 16'h2222);
    @(posedge clk); #1;
    @(negedge clk);
    op_s = S_OR; op_m = 1'b1; opa = 16'hAAAA; opb = 16'h5555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    donePulses = 0;
    resAtDone = '0;
    for (int k = 0; k < 3 * NIB; k++) begin
      if (done) begin donePulses++; resAtDone = result; end
      @(posedge clk); #1;
    end
    checkOutput("ignored_start_pulses", 32'(donePulses), 32'd1);
    checkOutput("ignored_start_result", 32'(resAtDone), 32'h3333);

    $display("[TB] back-to-back via start in DONE");
    applyStimulus(S_ADD, 1'b0, 1'b1, 16'h0F0F, 16'h0101);
    waitDone();
    checkResult(S_ADD, 1'b0, 1'b1, 16'h0F0F, 16'h0101);
    applyStimulus(S_SUB, 1'b0, 1'b0, 16'h9000, 16'h1234);
    checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
    checkOutput("b2b_done", {31'd0, done}, 32'd0);
    waitDone();
    checkResult(S_SUB, 1'b0, 1'b0, 16'h9000, 16'h1234);
    @(posedge clk); #1;

    $display("[TB] reset mid-run");
    applyStimulus(S_ADD, 1'b0, 1'b1, 16'h4321, 16'h1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_ = 1'b0;
    #1;
    checkResetValues("midrun");
    donePulses = 0;
    for (int k = 0; k < 2 * NIB; k++) begin
      @(posedge clk); #1;
      if (done) donePulses++;
    end
    checkOutput("midrun_no_done", 32'(donePulses), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    runOp(S_ADD, 1'b0, 1'b1, 16'h4321, 16'h1111);

    $display("[TB] randomized operations");
    for (int n = 0; n < 30; n++) begin
      pick = int'($urandom_range(0, 4));
      runOp(opS[pick], opM[pick], 1'($urandom), W'($urandom), W'($urandom));
    end

    refModel(S_ADD, 1'b0, 1'b1, 16'h1234, 16'h0FFF, r, co, ae);
    refModel(S_ADD, 1'b0, 1'b1, 16'h1234, r, r1, co, ae);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
